// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared state encoding, lane helpers and array defaults for the systolic feeder
package systolic_feeder_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_N        = 4;
  localparam int DEF_KW       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - DEPTH-stage delay line that gives one array lane its diagonal skew
module skew_line
  import systolic_feeder_pkg::*;
#(
  parameter int DEPTH    = 1,
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITWIDTH-1:0] i_data,
  output logic [BITWIDTH-1:0] o_data
);

  logic [BITWIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - feeds skewed A/B operand lanes into an N x N output-stationary array
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int N        = DEF_N,
  parameter int KW       = DEF_KW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KW-1:0]         kLen,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [N*BITWIDTH-1:0] inRowVec,
  input  logic [N*BITWIDTH-1:0] inColVec,
  output logic [N*BITWIDTH-1:0] oRow,
  output logic [N*BITWIDTH-1:0] oCol,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int DW = $clog2(2 * N);
  // The far corner PE folds in its last product 2N-1 edges after the final beat.
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 2);

  feeder_state_t r_state;
  feeder_state_t w_next;
  logic [KW-1:0] r_klen;
  logic [KW-1:0] r_beat;
  logic [DW-1:0] r_drain;
  logic          w_accept;
  logic          w_last_beat;

  assign w_accept    = (r_state == ST_FEED) && inValid;
  assign w_last_beat = (r_beat == r_klen - KW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_klen  <= '0;
      r_beat  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= (r_state == ST_DRAIN) ? r_drain + DW'(1) : '0;
      if (r_state == ST_IDLE && start && kLen != '0) begin
        r_klen <= kLen;
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + KW'(1);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    inReady = 1'b0;
    oBusy   = 1'b0;
    oDone   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (kLen == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        inReady = 1'b1;
        oBusy   = 1'b1;
        if (w_accept && w_last_beat) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        oBusy = 1'b1;
        if (r_drain == DRAIN_LAST) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        oDone  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bubbles push zeros so every lane keeps its fixed delay.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [BITWIDTH-1:0] w_row_in;
    logic [BITWIDTH-1:0] w_col_in;

    assign w_row_in = w_accept ? inRowVec[lane_lsb(i, BITWIDTH) +: BITWIDTH] : '0;
    assign w_col_in = w_accept ? inColVec[lane_lsb(i, BITWIDTH) +: BITWIDTH] : '0;

    skew_line #(.DEPTH(i + 1), .BITWIDTH(BITWIDTH)) u_row (
      .clk    (clk),
      .reset  (reset),
      .i_data (w_row_in),
      .o_data (oRow[lane_lsb(i, BITWIDTH) +: BITWIDTH])
    );

    skew_line #(.DEPTH(i + 1), .BITWIDTH(BITWIDTH)) u_col (
      .clk    (clk),
      .reset  (reset),
      .i_data (w_col_in),
      .o_data (oCol[lane_lsb(i, BITWIDTH) +: BITWIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized self-checking bench for systolic_feeder against a beat-schedule model
module tb_systolic_feeder;

  localparam int BW = 8;
  localparam int N  = 4;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] kLen;
  logic          inValid;
  logic          inReady;
  logic [N*BW-1:0] inRowVec;
  logic [N*BW-1:0] inColVec;
  logic [N*BW-1:0] oRow;
  logic [N*BW-1:0] oCol;
  logic          oBusy;
  logic          oDone;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [N*BW-1:0] h_row [16];
  logic [N*BW-1:0] h_col [16];
  int m_left;
  int m_done_cyc;
  int m_busy_end;

  logic [31:0] er;
  logic [31:0] ec;

  always #5 clk = ~clk;

  systolic_feeder #(.BITWIDTH(BW), .N(N), .KW(KW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .kLen     (kLen),
    .inValid  (inValid),
    .inReady  (inReady),
    .inRowVec (inRowVec),
    .inColVec (inColVec),
    .oRow     (oRow),
    .oCol     (oCol),
    .oBusy    (oBusy),
    .oDone    (oDone)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: each edge records what (if anything) was accepted; lane i shows the beat from i edges earlier.
  always @(posedge clk or posedge reset) begin
    int c;
    bit idle_prev;
    bit acc;
    if (reset) begin
      m_left     = 0;
      m_done_cyc = -1;
      m_busy_end = -100;
      for (int k = 0; k < 16; k++) begin
        h_row[k] = '0;
        h_col[k] = '0;
      end
    end else begin
      c = cyc + 1;
      idle_prev = (m_left == 0) && (c - 1 > m_busy_end) && (c - 1 != m_done_cyc);
      acc = (m_left > 0) && inValid;
      h_row[c & 15] = acc ? inRowVec : '0;
      h_col[c & 15] = acc ? inColVec : '0;
      if (acc) begin
        m_left--;
        if (m_left == 0) begin
          m_busy_end = c + 2 * N - 2;
          m_done_cyc = c + 2 * N - 1;
        end
      end
      if (idle_prev && start) begin
        if (kLen != 0) begin
          m_left     = int'(kLen);
          m_busy_end = 1 << 30;
        end else begin
          m_done_cyc = c;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N*BW-1:0] exp_row;
    logic [N*BW-1:0] exp_col;
    if (chk_en && !reset) begin
      for (int i = 0; i < N; i++) begin
        exp_row[i*BW +: BW] = h_row[(cyc - i) & 15][i*BW +: BW];
        exp_col[i*BW +: BW] = h_col[(cyc - i) & 15][i*BW +: BW];
      end
      check("inReady", inReady, m_left > 0);
      check("oBusy", oBusy, (m_left > 0) || (cyc <= m_busy_end));
      check("oDone", oDone, cyc == m_done_cyc);
      check("oRow", oRow, exp_row);
      check("oCol", oCol, exp_col);
    end
  end

  task automatic run_job(input int kl, input int pct);
    int guard;
    @(negedge clk);
    start = 1'b1;
    kLen  = KW'(kl);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    do begin
      inValid  = ($urandom_range(99) < pct);
      inRowVec = $urandom;
      inColVec = $urandom;
      start    = ($urandom_range(9) == 0);
      kLen     = KW'(9);
      @(negedge clk);
      guard++;
    end while ((m_left > 0 || cyc <= m_done_cyc) && guard < 500);
    start   = 1'b0;
    inValid = 1'b0;
    checks++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL job_timeout: job of %0d beats still active after %0d cycles", kl, guard);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; kLen = '0; inValid = 1'b0;
    inRowVec = '0; inColVec = '0;
    repeat (3) @(negedge clk);
    check("reset_oRow", oRow, 0);
    check("reset_oCol", oCol, 0);
    check("reset_busy", oBusy, 0);
    check("reset_done", oDone, 0);
    check("reset_ready", inReady, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Skew alignment: single beat walks diagonally across the lanes.
    @(negedge clk); start = 1'b1; kLen = 1;
    @(negedge clk); start = 1'b0; inValid = 1'b1;
    inRowVec = 32'h04030201; inColVec = 32'h08070605;
    @(negedge clk); inValid = 1'b0; inRowVec = '0; inColVec = '0;
    for (int k = 0; k < 9; k++) begin
      er = (k < N) ? (32'(k + 1) << (8 * k)) : 32'h0;
      ec = (k < N) ? (32'(k + 5) << (8 * k)) : 32'h0;
      check("skew_row", oRow, er);
      check("skew_col", oCol, ec);
      check("skew_done", oDone, k == 7);
      @(negedge clk);
    end

    // Zero-length job finishes right away.
    start = 1'b1; kLen = 0;
    @(negedge clk); start = 1'b0;
    check("k0_done", oDone, 1);
    check("k0_ready", inReady, 0);
    @(negedge clk);
    check("k0_done_clear", oDone, 0);

    // Reset after 2 of 3 beats clears outputs asynchronously.
    @(negedge clk); start = 1'b1; kLen = 3;
    @(negedge clk); start = 1'b0; inValid = 1'b1;
    inRowVec = 32'h11223344; inColVec = 32'h55667788;
    @(negedge clk);
    @(negedge clk); inValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_oRow", oRow, 0);
    check("midrst_oCol", oCol, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_ready", inReady, 0);
    check("midrst_done", oDone, 0);
    @(negedge clk); reset = 1'b0;

    run_job(3, 100);
    for (int j = 0; j < 40; j++) begin
      run_job($urandom_range(12), 30 + $urandom_range(70));
    end
    run_job(20, 100);
    run_job(1, 50);
    run_job(0, 50);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
